nucleo_tiempo: RTL and testbench

//  Timekeeping core of the digital clock. Directly downstream of the minute/hour adjust stages.

---
 rtl/nucleo_tiempo.sv | 128 ++++++++++++
 tb/tb_nucleo_tiempo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nucleo_tiempo.sv
// ---------------------------------------------------------------------------
// nucleo_tiempo
//   Timekeeping core of the digital clock. Keeps HH:MM:SS (24 h) from clkS
//   using a TICK_DIV prescaler. While either adjust switch is high the core
//   stops counting, holds seconds at 0 and loads the adjusted minute/hour
//   values coming from the adjust stages.
//
// Ports
//   clkS        in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   ajusteM     in   1  minute-adjust switch
//   minChange   in   6  adjusted minute value (accepted when 0..59)
//   ajusteH     in   1  hour-adjust switch
//   horaChange  in   5  adjusted hour value (accepted when 0..23)
//   segundos    out  6  seconds 0..59
//   minutos     out  6  minutes 0..59
//   horas       out  5  hours 0..23
//   min_bcd     out  8  minutes BCD {tens,units}, one cycle behind minutos
//   hora_bcd    out  8  hours BCD {tens,units}, one cycle behind horas
//   tick_1hz    out  1  one-cycle pulse with every seconds increment
//   fin_dia     out  1  one-cycle pulse on 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module nucleo_tiempo #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clkS,
    input  logic       reset,
    input  logic       ajusteM,
    input  logic [5:0] minChange,
    input  logic       ajusteH,
    input  logic [4:0] horaChange,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [4:0] horas,
    output logic [7:0] min_bcd,
    output logic [7:0] hora_bcd,
    output logic       tick_1hz,
    output logic       fin_dia
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] AJUSTE = 1'b1;

    logic [0:0]    state;
    logic [0:0]    stateNext;
    logic [PW-1:0] pre;
    logic [PW-1:0] preBase;

    // Binary value -> {tens,units}; inputs are always 0..59 so no invalid codes.
    function automatic logic [7:0] aBcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // The switches act in the same cycle they are seen, so a switch rising on
    // a tick cycle suppresses that tick.
    always_comb begin
        stateNext = (ajusteM || ajusteH) ? AJUSTE : RUN;
    end

    // On the first RUN cycle after adjusting the prescaler restarts from 0
    // whatever it holds, so the first tick lands TICK_DIV cycles later.
    always_comb begin
        preBase = (state == AJUSTE) ? '0 : pre;
    end

    // Stage: binary time registers
    always_ff @(posedge clkS) begin
        if (reset) begin
            state    <= RUN;
            pre      <= '0;
            segundos <= '0;
            minutos  <= '0;
            horas    <= '0;
            tick_1hz <= 1'b0;
            fin_dia  <= 1'b0;
        end else begin
            state    <= stateNext;
            tick_1hz <= 1'b0;
            fin_dia  <= 1'b0;
            if (stateNext == AJUSTE) begin
                pre      <= '0;
                segundos <= '0;
                if (ajusteM && (minChange <= 6'd59)) begin
                    minutos <= minChange;
                end
                if (ajusteH && (horaChange <= 5'd23)) begin
                    horas <= horaChange;
                end
            end else if (preBase == PRE_LAST) begin
                pre      <= '0;
                tick_1hz <= 1'b1;
                if (segundos == 6'd59) begin
                    segundos <= '0;
                    if (minutos == 6'd59) begin
                        minutos <= '0;
                        if (horas == 5'd23) begin
                            horas   <= '0;
                            fin_dia <= 1'b1;
                        end else begin
                            horas <= horas + 1'b1;
                        end
                    end else begin
                        minutos <= minutos + 1'b1;
                    end
                end else begin
                    segundos <= segundos + 1'b1;
                end
            end else begin
                pre <= preBase + 1'b1;
            end
        end
    end

    // Stage: BCD conversion of the registered binary time
    always_ff @(posedge clkS) begin
        if (reset) begin
            min_bcd  <= 8'h00;
            hora_bcd <= 8'h00;
        end else begin
            min_bcd  <= aBcd(minutos);
            hora_bcd <= aBcd({1'b0, horas});
        end
    end

endmodule

// File: tb/tb_nucleo_tiempo.sv
// ---------------------------------------------------------------------------
// tb_nucleo_tiempo
//   Self-checking bench for nucleo_tiempo (TICK_DIV = 4). The reference model
//   keeps time as a count of seconds since midnight plus a count of running
//   cycles since the last tick/adjust/reset.
// ---------------------------------------------------------------------------
module tb_nucleo_tiempo;

    localparam int TICK_DIV = 4;

    logic       clkS = 1'b0;
    logic       reset = 1'b1;
    logic       ajusteM = 1'b0;
    logic [5:0] minChange = '0;
    logic       ajusteH = 1'b0;
    logic [4:0] horaChange = '0;
    logic [5:0] segundos;
    logic [5:0] minutos;
    logic [4:0] horas;
    logic [7:0] min_bcd;
    logic [7:0] hora_bcd;
    logic       tick_1hz;
    logic       fin_dia;

    nucleo_tiempo #(.TICK_DIV(TICK_DIV)) dut (
        .clkS(clkS), .reset(reset),
        .ajusteM(ajusteM), .minChange(minChange),
        .ajusteH(ajusteH), .horaChange(horaChange),
        .segundos(segundos), .minutos(minutos), .horas(horas),
        .min_bcd(min_bcd), .hora_bcd(hora_bcd),
        .tick_1hz(tick_1hz), .fin_dia(fin_dia)
    );

    always #5 clkS = ~clkS;

    int nCompared = 0;
    int nMismatch = 0;

    // Reference state
    int mSecs = 0;
    int mRun = 0;
    int mTick = 0;
    int mFin = 0;
    int mMinBcd = 0;
    int mHoraBcd = 0;

    function automatic int toBcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic comparar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatch++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelo();
        int h;
        int m;
        h = mSecs / 3600;
        m = (mSecs / 60) % 60;
        if (reset) begin
            mSecs = 0; mRun = 0; mTick = 0; mFin = 0; mMinBcd = 0; mHoraBcd = 0;
        end else begin
            mMinBcd = toBcd(m);
            mHoraBcd = toBcd(h);
            mTick = 0;
            mFin = 0;
            if (ajusteM || ajusteH) begin
                if (ajusteM && minChange <= 59) m = int'(minChange);
                if (ajusteH && horaChange <= 23) h = int'(horaChange);
                mSecs = h * 3600 + m * 60;
                mRun = 0;
            end else begin
                mRun++;
                if (mRun == TICK_DIV) begin
                    mRun = 0;
                    mSecs = (mSecs + 1) % 86400;
                    mTick = 1;
                    mFin = (mSecs == 0) ? 1 : 0;
                end
            end
        end
    endtask

    // One clock: update the model at the edge, check all outputs 1 ns later.
    task automatic ciclo();
        @(posedge clkS);
        modelo();
        #1;
        comparar("segundos", 32'(segundos), 32'(mSecs % 60));
        comparar("minutos",  32'(minutos),  32'((mSecs / 60) % 60));
        comparar("horas",    32'(horas),    32'(mSecs / 3600));
        comparar("min_bcd",  32'(min_bcd),  32'(mMinBcd));
        comparar("hora_bcd", 32'(hora_bcd), 32'(mHoraBcd));
        comparar("tick_1hz", 32'(tick_1hz), 32'(mTick));
        comparar("fin_dia",  32'(fin_dia),  32'(mFin));
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) ciclo();
    endtask

    task automatic switches(input logic am, input logic [5:0] mc, input logic ah, input logic [4:0] hc);
        ajusteM = am; minChange = mc; ajusteH = ah; horaChange = hc;
    endtask

    initial begin
        int ticks;
        int fins;
        int firstTick;

        // Reset state
        ciclos(2);
        comparar("reset_segundos", 32'(segundos), 32'd0);
        comparar("reset_bcd", 32'({min_bcd, hora_bcd}), 32'd0);
        reset = 1'b0;

        // Free run: ticks every 4 cycles
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            ciclo();
            ticks += int'(tick_1hz);
        end
        comparar("run_seg_after8", 32'(segundos), 32'd2);
        comparar("run_ticks8", 32'(ticks), 32'd2);
        comparar("run_min_bcd", 32'(min_bcd), 32'h00);
        ciclos(12);

        // Preload 00:59, run one minute: 01:00:00
        switches(1'b1, 6'd59, 1'b1, 5'd0);
        ciclo();
        switches(1'b0, 6'd0, 1'b0, 5'd0);
        ciclos(60 * TICK_DIV);
        comparar("carry_min", 32'(minutos), 32'd0);
        comparar("carry_hora", 32'(horas), 32'd1);
        ciclo();
        comparar("carry_hora_bcd", 32'(hora_bcd), 32'h01);

        // 23:59 -> midnight
        switches(1'b1, 6'd59, 1'b1, 5'd23);
        ciclo();
        switches(1'b0, 6'd0, 1'b0, 5'd0);
        fins = 0;
        for (int i = 0; i < 60 * TICK_DIV + 8; i++) begin
            ciclo();
            if (fin_dia) begin
                fins++;
                comparar("fin_with_tick", 32'(tick_1hz), 32'd1);
                comparar("fin_midnight", 32'({horas, minutos, segundos}), 32'd0);
            end
        end
        comparar("fin_count", 32'(fins), 32'd1);

        // Minute adjust mid-count, then out-of-range value
        ciclos(6);
        switches(1'b1, 6'd37, 1'b0, 5'd0);
        ciclo();
        comparar("adj_min", 32'(minutos), 32'd37);
        comparar("adj_seg", 32'(segundos), 32'd0);
        ciclo();
        comparar("adj_min_bcd", 32'(min_bcd), 32'h37);
        minChange = 6'd60;
        ciclos(3);
        comparar("adj_min_hold", 32'(minutos), 32'd37);
        comparar("adj_no_tick", 32'(tick_1hz), 32'd0);

        // Switch rises on the cycle a tick is due
        switches(1'b0, 6'd0, 1'b0, 5'd0);
        for (int i = 0; i < 10 && mRun != TICK_DIV - 1; i++) ciclo();
        comparar("sync_tick_due", 32'(mRun), 32'(TICK_DIV - 1));
        switches(1'b1, 6'd37, 1'b0, 5'd0);
        ciclo();
        comparar("sync_no_tick", 32'(tick_1hz), 32'd0);
        comparar("sync_seg0", 32'(segundos), 32'd0);
        switches(1'b0, 6'd0, 1'b0, 5'd0);
        firstTick = 0;
        for (int i = 1; i <= 2 * TICK_DIV && firstTick == 0; i++) begin
            ciclo();
            if (tick_1hz) firstTick = i;
        end
        comparar("sync_first_tick", 32'(firstTick), 32'(TICK_DIV));

        // Reset during hour adjust
        switches(1'b0, 6'd0, 1'b1, 5'd12);
        ciclo();
        reset = 1'b1;
        ciclo();
        comparar("rst_adj_outs", 32'({segundos, minutos, horas, tick_1hz, fin_dia}), 32'd0);
        comparar("rst_adj_bcd", 32'({min_bcd, hora_bcd}), 32'd0);
        reset = 1'b0;
        ciclo();
        comparar("rst_adj_horas", 32'(horas), 32'd12);
        switches(1'b0, 6'd0, 1'b0, 5'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 400) == 0) reset = 1'b1;
            else reset = 1'b0;
            if (ajusteM || ajusteH) begin
                if (($urandom % 4) == 0) switches(1'b0, 6'd0, 1'b0, 5'd0);
                else begin
                    minChange = 6'($urandom_range(0, 63));
                    horaChange = 5'($urandom_range(0, 31));
                end
            end else if (($urandom % 40) == 0) begin
                logic am;
                am = 1'($urandom_range(0, 1));
                switches(am,
                         (($urandom % 3) == 0) ? 6'd59 : 6'($urandom_range(0, 63)),
                         !am || 1'($urandom_range(0, 1)),
                         (($urandom % 3) == 0) ? 5'd23 : 5'($urandom_range(0, 31)));
            end
            ciclo();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
